ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
// ID/EX pipeline register plus EX-stage operand forwarding and load-use hazard detection.
// Captures decoded instruction fields from ID and forwards EX/MEM and MEM/WB results into the operands.
// Selects register or immediate for operand B and drives the ALU's a, b and aluop inputs directly.
// Carries the control bits downstream to the EX/MEM register.
// PARAMETERS
// DW     32  datapath width; the ALU is fixed at 32, so only 32 is supported
// RW      5  register index width
// IMMW   16  immediate width before extension
// PORTS
// clk            in   1   rising-edge clock
// nrst           in   1   asynchronous active-low reset
// id_valid       in   1   ID holds a real instruction
// id_rs, id_rt   in   RW  source register indices
// id_rd          in   RW  destination index, already resolved to rt or rd by ID
// id_rs_data     in   DW  register-file read of rs
// id_rt_data     in   DW  register-file read of rt
// id_imm         in   IMMW raw immediate
// id_immzx       in   1   1 = zero-extend the immediate, 0 = sign-extend
// id_alusrc      in   1   1 = operand B is the extended immediate
// id_uses_rt     in   1   instruction reads rt, as a register operand or store data
// id_aluop       in   3   ALU operation code
// id_regwrite    in   1   control bit carried to EX/MEM
// id_memread     in   1   control bit carried to EX/MEM
// id_memwrite    in   1   control bit carried to EX/MEM
// id_memtoreg    in   1   control bit carried to EX/MEM
// flush          in   1   kill the instruction entering EX (taken branch)
// hold           in   1   downstream stall; freeze this stage
// exmem_regwrite in   1   EX/MEM forwarding source: write enable
// exmem_rd       in   RW  EX/MEM forwarding source: destination index
// exmem_result   in   DW  EX/MEM forwarding source: result value
// memwb_regwrite in   1   MEM/WB forwarding source: write enable
// memwb_rd       in   RW  MEM/WB forwarding source: destination index
// memwb_result   in   DW  MEM/WB forwarding source: result value
// alu_a, alu_b   out  DW  ALU operands
// alu_aluop      out  3   ALU operation code
// ex_valid       out  1   EX holds a real instruction
// ex_rd          out  RW  registered destination index
// ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out 1  registered control, gated by ex_valid
// ex_store_data  out  DW  forwarded rt value, used as store data
// hz_stall       out  1   combinational; ID and PC must hold this cycle
// BEHAVIOUR
// - Reset (nrst=0, async): every register clears to 0, so ex_valid=0, all control bits 0 and alu_aluop=0 (ADD). Outputs are 0 whenever they derive from registers only.
// - hz_stall = id_valid & ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
// - Register update priority at each clk edge: flush > hold > hz_stall > load.
//   - flush: load a bubble; valid and all control bits become 0 and the data fields are don't-care.
//   - hold: keep all fields, but rs_data/rt_data re-capture the current forwarded values so a producer retiring during the hold is not lost.
//   - hz_stall (without hold): load a bubble; ID re-presents the same instruction next cycle.
//   - load: capture all id_* fields; the immediate is extended per id_immzx.
// - Forwarding is combinational from the registered fields, computed separately for rs and rt:
//   - Source is EX/MEM when exmem_regwrite & exmem_rd!=0 & exmem_rd==idx.
//   - Otherwise MEM/WB when memwb_regwrite & memwb_rd!=0 & memwb_rd==idx.
//   - Otherwise the registered register-file value. EX/MEM wins when both match.
//   - Register 0 is never forwarded.
// - Operand drive:
//   - alu_a = fwd_rs.
//   - alu_b = alusrc ? ext_imm : fwd_rt.
//   - ex_store_data = fwd_rt.
// - Latency: one cycle from ID capture to valid ALU operands. Throughput is 1 per cycle when there is no hazard.
// - A bubble drives aluop=0 and control=0, so the ALU output is ignored downstream.
// - Immediate extension: 0x8000 becomes 0xFFFF8000 when signed and 0x00008000 when zero-extended. LUI (aluop 7) uses the low 16 bits of alu_b, so extension mode does not matter for it.
// STRUCTURE
// - Shared package `pipe_defs`:
//   - ALU opcodes ALU_ADD=0 SUB=1 AND=2 OR=3 XOR=4 NOR=5 SLT=6 LUI=7.
//   - Forward-select encodings FWD_RF=0, FWD_MEM=1, FWD_WB=2.
//   - Width constants DW and RW.
// - Sub-module `ex_fwd_mux`: one index compare plus a 3:1 mux. Instantiate it twice, for rs and rt.
// - Top level contains the register bank, hazard logic, immediate extension and the B-operand mux.
// TESTING
// 1) Reset mid-operation: drop nrst while ex_valid=1 -> all outputs 0 immediately, without waiting for clk.
// 2) EX/MEM forwarding: load rs=3, rs_data=0x11; set exmem_rd=3, regwrite=1, result=0x55 -> alu_a=0x55.
//    - Same setup with memwb_rd=3 and result 0x66 also matching -> alu_a still 0x55 (EX/MEM priority).
// 3) Register 0: exmem_rd=0, regwrite=1, result=0xDEAD, rs=0, rs_data=0 -> alu_a=0.
// 4) Load-use: EX holds a memread to rd=5 while ID has rt=5, id_uses_rt=1.
//    - hz_stall=1 for exactly one cycle and a bubble enters EX (ex_valid=0).
//    - Next cycle the reissued instruction gets alu_b from memwb_result.
// 5) Hold with retiring producer: hold=1 for 2 cycles while MEM/WB writes rd=7=0x77, and EX uses rs=7.
//    - After hold drops, alu_a=0x77 even though MEM/WB has moved on.
// 6) Flush over hold: flush=1 and hold=1 together -> ex_valid=0 next cycle.
//    - Immediate checks: id_imm=0x8000, alusrc=1, immzx=0 -> alu_b=0xFFFF8000; with immzx=1 -> alu_b=0x00008000.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared pipeline definitions: datapath widths, ALU opcodes, forward-select codes,
// the ID/EX register layout and the immediate-extension helper.
package pipe_defs;

    localparam int unsigned DW   = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned IMMW = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOR = 3'd5,
        ALU_SLT = 3'd6,
        ALU_LUI = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rs;
        logic [RW-1:0]   rt;
        logic [RW-1:0]   rd;
        logic [DW-1:0]   rs_data;
        logic [DW-1:0]   rt_data;
        logic [DW-1:0]   imm_ext;
        logic            alusrc;
        alu_op_e         aluop;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
    } ex_reg_t;

    // Extension is resolved at capture so EX only ever sees a full-width immediate.
    function automatic logic [DW-1:0] ext_imm(input logic [IMMW-1:0] imm, input logic zx);
        logic fill;
        fill = zx ? 1'b0 : imm[IMMW-1];
        return {{(DW-IMMW){fill}}, imm};
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID-to-EX bundle: decoded instruction, stage control, forwarding sources and
// the EX-side outputs toward the ALU and the EX/MEM register.
interface ex_operand_stage_if;
    import pipe_defs::*;

    logic            id_valid;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic [RW-1:0]   id_rd;
    logic [DW-1:0]   id_rs_data;
    logic [DW-1:0]   id_rt_data;
    logic [IMMW-1:0] id_imm;
    logic            id_immzx;
    logic            id_alusrc;
    logic            id_uses_rt;
    logic [2:0]      id_aluop;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic            id_memtoreg;
    logic            flush;
    logic            hold;
    logic            exmem_regwrite;
    logic [RW-1:0]   exmem_rd;
    logic [DW-1:0]   exmem_result;
    logic            memwb_regwrite;
    logic [RW-1:0]   memwb_rd;
    logic [DW-1:0]   memwb_result;

    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [2:0]      alu_aluop;
    logic            ex_valid;
    logic [RW-1:0]   ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_memtoreg;
    logic [DW-1:0]   ex_store_data;
    logic            hz_stall;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_immzx,
               id_alusrc, id_uses_rt, id_aluop, id_regwrite, id_memread, id_memwrite,
               id_memtoreg, flush, hold, exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  alu_a, alu_b, alu_aluop, ex_valid, ex_rd, ex_regwrite, ex_memread,
               ex_memwrite, ex_memtoreg, ex_store_data, hz_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_immzx,
               id_alusrc, id_uses_rt, id_aluop, id_regwrite, id_memread, id_memwrite,
               id_memtoreg, flush, hold, exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output alu_a, alu_b, alu_aluop, ex_valid, ex_rd, ex_regwrite, ex_memread,
               ex_memwrite, ex_memtoreg, ex_store_data, hz_stall
    );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// One operand's forwarding path: pick EX/MEM, then MEM/WB, then the register-file
// value captured in ID/EX. Register 0 is hard-wired and never forwarded.
module ex_fwd_mux
    import pipe_defs::*;
(
    input  logic [RW-1:0] idx_i,
    input  logic [DW-1:0] rf_data_i,
    input  logic          exmem_regwrite_i,
    input  logic [RW-1:0] exmem_rd_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic          memwb_regwrite_i,
    input  logic [RW-1:0] memwb_rd_i,
    input  logic [DW-1:0] memwb_result_i,
    output logic [DW-1:0] data_o
);

    fwd_sel_e sel_s;

    // Source select; the younger EX/MEM result wins when both stages match.
    always_comb begin
        sel_s = FWD_RF;
        if (exmem_regwrite_i && (exmem_rd_i != {RW{1'b0}}) && (exmem_rd_i == idx_i)) begin
            sel_s = FWD_MEM;
        end else if (memwb_regwrite_i && (memwb_rd_i != {RW{1'b0}}) && (memwb_rd_i == idx_i)) begin
            sel_s = FWD_WB;
        end else begin
            sel_s = FWD_RF;
        end
    end

    // Operand data mux.
    always_comb begin
        data_o = rf_data_i;
        case (sel_s)
            FWD_MEM: data_o = exmem_result_i;
            FWD_WB:  data_o = memwb_result_i;
            FWD_RF:  data_o = rf_data_i;
            default: data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, load-use hazard
// detection, immediate extension and the ALU B-operand select.
module ex_operand_stage
    import pipe_defs::*;
(
    input  logic               clk,
    input  logic               nrst,
    ex_operand_stage_if.slave  bus
);

    ex_reg_t       ex_q;
    ex_reg_t       ex_d;
    logic [DW-1:0] fwd_rs_s;
    logic [DW-1:0] fwd_rt_s;
    logic          hz_stall_s;

    ex_fwd_mux u_fwd_rs (
        .idx_i            (ex_q.rs),
        .rf_data_i        (ex_q.rs_data),
        .exmem_regwrite_i (bus.exmem_regwrite),
        .exmem_rd_i       (bus.exmem_rd),
        .exmem_result_i   (bus.exmem_result),
        .memwb_regwrite_i (bus.memwb_regwrite),
        .memwb_rd_i       (bus.memwb_rd),
        .memwb_result_i   (bus.memwb_result),
        .data_o           (fwd_rs_s)
    );

    ex_fwd_mux u_fwd_rt (
        .idx_i            (ex_q.rt),
        .rf_data_i        (ex_q.rt_data),
        .exmem_regwrite_i (bus.exmem_regwrite),
        .exmem_rd_i       (bus.exmem_rd),
        .exmem_result_i   (bus.exmem_result),
        .memwb_regwrite_i (bus.memwb_regwrite),
        .memwb_rd_i       (bus.memwb_rd),
        .memwb_result_i   (bus.memwb_result),
        .data_o           (fwd_rt_s)
    );

    // A load in EX cannot forward its data in time to the instruction behind it.
    assign hz_stall_s = bus.id_valid & ex_q.valid & ex_q.memread
                      & (ex_q.rd != {RW{1'b0}})
                      & ((ex_q.rd == bus.id_rs) | (bus.id_uses_rt & (ex_q.rd == bus.id_rt)));

    // Next-state select: flush > hold > load-use bubble > normal capture.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.hold) begin
            // Re-capture forwarded values so a producer retiring during the hold is kept.
            ex_d.rs_data = fwd_rs_s;
            ex_d.rt_data = fwd_rt_s;
        end else if (hz_stall_s) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = bus.id_valid;
            ex_d.rs       = bus.id_rs;
            ex_d.rt       = bus.id_rt;
            ex_d.rd       = bus.id_rd;
            ex_d.rs_data  = bus.id_rs_data;
            ex_d.rt_data  = bus.id_rt_data;
            ex_d.imm_ext  = ext_imm(bus.id_imm, bus.id_immzx);
            ex_d.alusrc   = bus.id_alusrc;
            ex_d.aluop    = alu_op_e'(bus.id_aluop);
            ex_d.regwrite = bus.id_regwrite;
            ex_d.memread  = bus.id_memread;
            ex_d.memwrite = bus.id_memwrite;
            ex_d.memtoreg = bus.id_memtoreg;
        end
    end

    // ID/EX register bank.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.alu_a         = fwd_rs_s;
    assign bus.alu_b         = ex_q.alusrc ? ex_q.imm_ext : fwd_rt_s;
    assign bus.alu_aluop     = ex_q.aluop;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_regwrite   = ex_q.valid & ex_q.regwrite;
    assign bus.ex_memread    = ex_q.valid & ex_q.memread;
    assign bus.ex_memwrite   = ex_q.valid & ex_q.memwrite;
    assign bus.ex_memtoreg   = ex_q.valid & ex_q.memtoreg;
    assign bus.ex_store_data = fwd_rt_s;
    assign bus.hz_stall      = hz_stall_s;

endmodule
